// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle logic/arith ops, iterative shifts and
// shift-add multiply, persistent N/Z/V/C flags for carry chaining.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_sel,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    input  logic             use_flag_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             c_out,
    output logic [3:0]       flags,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_NAND = 4'd6;
    localparam logic [3:0] OP_SHL  = 4'd7;
    localparam logic [3:0] OP_SHR  = 4'd8;
    localparam logic [3:0] OP_ASL  = 4'd9;
    localparam logic [3:0] OP_ASR  = 4'd10;
    localparam logic [3:0] OP_ROL  = 4'd11;
    localparam logic [3:0] OP_NOT  = 4'd12;
    localparam logic [3:0] OP_MUL  = 4'd13;

    typedef enum logic {IDLE, EXEC} state_t;

    // One-bit shift step; returns {bit shifted out, shifted value}.
    function automatic logic [WIDTH:0] shift_step(input logic [3:0] o, input logic [WIDTH-1:0] v);
        case (o)
            OP_SHR:  return {v[0], 1'b0, v[WIDTH-1:1]};
            OP_ASR:  return {v[0], v[WIDTH-1], v[WIDTH-1:1]};
            OP_ROL:  return {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
            default: return {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
        endcase
    endfunction

    // One shift-add multiply step: product register holds {partial, multiplier}.
    function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] p, input logic [WIDTH-1:0] m);
        logic [WIDTH:0] s;
        s = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
        return {s, p[WIDTH-1:1]};
    endfunction

    state_t              state;
    logic [3:0]          op;
    logic [WIDTH-1:0]    mcand;
    logic [2*WIDTH-1:0]  prod;
    logic [WIDTH-1:0]    sh_val;
    logic [CW-1:0]       cnt;

    logic                cin_eff;
    logic                is_shift, is_mul, multi;
    logic [CW-1:0]       cnt_sel;
    logic [WIDTH:0]      first, sh_next, sum;
    logic [2*WIDTH-1:0]  mul_first, mul_next;
    logic [WIDTH-1:0]    sc_res;
    logic                sc_c, sc_v;

    assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
    assign cin_eff   = use_flag_c ? flags[0] : c_in;
    assign is_shift  = (alu_sel >= OP_SHL) && (alu_sel <= OP_ROL);
    assign is_mul    = (alu_sel == OP_MUL);
    assign first     = shift_step(alu_sel, a_in);
    assign mul_first = mul_step({{WIDTH{1'b0}}, b_in}, a_in);
    assign sh_next   = shift_step(op, sh_val);
    assign mul_next  = mul_step(prod, mcand);
    assign multi     = is_mul || (is_shift && cnt_sel >= CW'(2));

    // Shifts saturate at WIDTH; rotate wraps modulo WIDTH.
    always_comb begin
        cnt_sel = '0;
        if (alu_sel == OP_ROL)
            cnt_sel = {1'b0, b_in[CW-2:0]};
        else if (b_in >= WIDTH'(WIDTH))
            cnt_sel = CW'(WIDTH);
        else
            cnt_sel = b_in[CW-1:0];
    end

    always_comb begin
        sum    = '0;
        sc_res = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        case (alu_sel)
            OP_ADD: begin
                sum    = {1'b0, a_in} + {1'b0, b_in} + (WIDTH+1)'(cin_eff);
                sc_res = sum[WIDTH-1:0];
                sc_c   = sum[WIDTH];
                sc_v   = (a_in[WIDTH-1] == b_in[WIDTH-1]) && (sc_res[WIDTH-1] != a_in[WIDTH-1]);
            end
            OP_SUB: begin
                sum    = {1'b0, a_in} + {1'b0, ~b_in} + (WIDTH+1)'(cin_eff);
                sc_res = sum[WIDTH-1:0];
                sc_c   = sum[WIDTH];
                sc_v   = (a_in[WIDTH-1] != b_in[WIDTH-1]) && (sc_res[WIDTH-1] != a_in[WIDTH-1]);
            end
            OP_AND:  sc_res = a_in & b_in;
            OP_XOR:  sc_res = a_in ^ b_in;
            OP_NOR:  sc_res = ~(a_in | b_in);
            OP_NAND: sc_res = ~(a_in & b_in);
            OP_NOT:  sc_res = ~a_in;
            OP_SHL, OP_SHR, OP_ASL, OP_ASR, OP_ROL: begin
                if (cnt_sel != '0) begin
                    sc_res = first[WIDTH-1:0];
                    sc_c   = first[WIDTH];
                end else begin
                    sc_res = a_in;
                end
            end
            // OR, the two spare opcodes; MUL never uses this path
            default: sc_res = a_in | b_in;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op        <= '0;
            mcand     <= '0;
            prod      <= '0;
            sh_val    <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out       <= '0;
            c_out     <= 1'b0;
            flags     <= '0;
            busy      <= 1'b0;
        end else begin
            if (out_ready)
                out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        if (multi) begin
                            // The accept edge performs the first iteration.
                            state  <= EXEC;
                            busy   <= 1'b1;
                            op     <= alu_sel;
                            mcand  <= a_in;
                            prod   <= mul_first;
                            sh_val <= first[WIDTH-1:0];
                            cnt    <= is_mul ? CW'(WIDTH - 1) : cnt_sel - CW'(1);
                        end else begin
                            out       <= sc_res;
                            c_out     <= sc_c;
                            flags     <= {sc_res[WIDTH-1], sc_res == '0, sc_v, sc_c};
                            out_valid <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    prod   <= mul_next;
                    sh_val <= sh_next[WIDTH-1:0];
                    cnt    <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        if (op == OP_MUL) begin
                            out   <= mul_next[WIDTH-1:0];
                            c_out <= |mul_next[2*WIDTH-1:WIDTH];
                            flags <= {mul_next[WIDTH-1], mul_next[WIDTH-1:0] == '0,
                                      |mul_next[2*WIDTH-1:WIDTH], |mul_next[2*WIDTH-1:WIDTH]};
                        end else begin
                            out   <= sh_next[WIDTH-1:0];
                            c_out <= sh_next[WIDTH];
                            flags <= {sh_next[WIDTH-1], sh_next[WIDTH-1:0] == '0, 1'b0, sh_next[WIDTH]};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed vectors, expected results queued at
// accept and compared by an independent monitor when the result is consumed.
module tb_alu_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [3:0]  alu_sel;
    logic [15:0] a_in, b_in;
    logic        c_in, use_flag_c;
    logic        out_valid, out_ready;
    logic [15:0] out;
    logic        c_out;
    logic [3:0]  flags;
    logic        busy;

    typedef struct packed {
        logic [15:0] o;
        logic        c;
        logic [3:0]  f;
    } exp_t;

    exp_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    alu_seq #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_sel(alu_sel), .a_in(a_in), .b_in(b_in),
        .c_in(c_in), .use_flag_c(use_flag_c),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .c_out(c_out), .flags(flags), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // Monitor: the result is consumed at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("unexpected_result", 32'(out), 32'hDEAD_BEEF);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("out",   32'(out),   32'(e.o));
                check("c_out", 32'(c_out), 32'(e.c));
                check("flags", 32'(flags), 32'(e.f));
            end
        end
    end

    // Called just after a rising edge; returns just after the accept edge.
    task automatic issue(input logic [3:0] sel, input logic [15:0] a, input logic [15:0] b,
                         input logic ci, input logic uf,
                         input logic [15:0] eo, input logic ec, input logic [3:0] ef);
        int t = 0;
        alu_sel = sel; a_in = a; b_in = b; c_in = ci; use_flag_c = uf; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("issue_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        q.push_back('{o: eo, c: ec, f: ef});
    endtask

    task automatic wait_lat(input string nm, input int exp);
        int lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check(nm, 32'(lat), 32'(exp));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; in_valid = 1'b0; alu_sel = '0; a_in = '0; b_in = '0;
        c_in = 1'b0; use_flag_c = 1'b0; out_ready = 1'b1;
        idle(2);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out",       32'(out),       32'd0);
        check("rst_flags",     32'(flags),     32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        rst_n = 1'b1;
        idle(1);

        // Carry chain: second ADD takes C from the first one's flags.
        issue(4'd0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 4'b0101);
        issue(4'd0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0, 4'b0000);
        idle(2);
        issue(4'd1, 16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 4'b1000);
        wait_lat("lat_sub", 1);
        issue(4'd1, 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 4'b0011);
        issue(4'd5, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'hFFFF, 1'b0, 4'b1000);
        issue(4'd12, 16'hFFFF, 16'h1234, 1'b0, 1'b0, 16'h0000, 1'b0, 4'b0100);
        issue(4'd14, 16'h0F00, 16'h00F0, 1'b0, 1'b0, 16'h0FF0, 1'b0, 4'b0000);
        issue(4'd8, 16'h1234, 16'h0000, 1'b0, 1'b0, 16'h1234, 1'b0, 4'b0000);
        issue(4'd11, 16'h8001, 16'd17, 1'b0, 1'b0, 16'h0003, 1'b1, 4'b0001);
        wait_lat("lat_rol1", 1);
        idle(1);
        issue(4'd10, 16'h8000, 16'd4, 1'b0, 1'b0, 16'hF800, 1'b0, 4'b1000);
        wait_lat("lat_asr4", 4);
        idle(1);
        issue(4'd8, 16'h00F0, 16'd5, 1'b0, 1'b0, 16'h0007, 1'b1, 4'b0001);
        wait_lat("lat_shr5", 5);
        idle(1);
        issue(4'd7, 16'h0001, 16'd20, 1'b0, 1'b0, 16'h0000, 1'b1, 4'b0101);
        wait_lat("lat_shl20", 16);
        idle(1);
        issue(4'd13, 16'h0100, 16'h0100, 1'b0, 1'b0, 16'h0000, 1'b1, 4'b0111);
        wait_lat("lat_mul", 16);
        idle(1);
        issue(4'd13, 16'h0003, 16'h0005, 1'b0, 1'b0, 16'h000F, 1'b0, 4'b0000);
        wait_lat("lat_mul2", 16);
        idle(2);

        // Backpressure: stalled OR result blocks a pending XOR request.
        out_ready = 1'b0;
        issue(4'd2, 16'h00F0, 16'h0F00, 1'b0, 1'b0, 16'h0FF0, 1'b0, 4'b0000);
        alu_sel = 4'd4; a_in = 16'hFFFF; b_in = 16'h00FF; c_in = 1'b0; use_flag_c = 1'b0;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out",      32'(out),      32'h0FF0);
            check("stall_valid",    32'(out_valid), 32'd1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        q.push_back('{o: 16'hFF00, c: 1'b0, f: 4'b1000});
        idle(2);

        // Reset in the middle of a multiply drops it.
        issue(4'd7, 16'h0001, 16'd20, 1'b0, 1'b0, 16'h0000, 1'b1, 4'b0101);
        wait_lat("lat_shl20b", 16);
        idle(2);
        issue(4'd13, 16'h0100, 16'h0100, 1'b0, 1'b0, 16'h0000, 1'b1, 4'b0111);
        idle(7);
        rst_n = 1'b0;
        void'(q.pop_back());
        #1;
        check("midrst_valid",    32'(out_valid), 32'd0);
        check("midrst_flags",    32'(flags),     32'd0);
        check("midrst_busy",     32'(busy),      32'd0);
        check("midrst_in_ready", 32'(in_ready),  32'd1);
        idle(1);
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("no_stale_result", 32'(seen), 32'd0);

        begin
            int t = 0;
            while (q.size() != 0 && t < 100) begin
                @(posedge clk);
                t++;
            end
        end
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
